// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with fixed or round-robin priority and a
// valid/ready output handshake; a stalled grant is held as a frozen snapshot.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] g_p0;
  logic         any_p0;
  logic         multi_p0;
  logic         load_p0;

  // Highest set index wins.
  function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
    logic [W-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      if (r[k]) g = W'(k);
    end
    return g;
  endfunction

  // Search downward from p, wrapping from 0 to N-1; first set bit wins.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W-1:0] g;
    logic [W-1:0] j;
    logic         found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(p) + N - k) % N);
      if (!found && r[j]) begin
        g     = j;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Stage p0: combinational grant select
  always_comb begin
    any_p0   = |req;
    multi_p0 = ($countones(req) > 1);
    g_p0     = rr_en ? rr_pick(req, ptr) : fixed_pick(req);
    load_p0  = !out_valid || out_ready;
  end

  // Stage p1: registered grant and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      ptr        <= W'(N - 1);
    end else if (load_p0) begin
      if (any_p0) begin
        out_valid  <= 1'b1;
        out_idx    <= g_p0;
        out_onehot <= N'(1) << g_p0;
        out_multi  <= multi_p0;
        if (rr_en) ptr <= (g_p0 == '0) ? W'(N - 1) : g_p0 - 1'b1;
      end else begin
        // Empty request: drop valid but keep the last index and pointer.
        out_valid  <= 1'b0;
        out_onehot <= '0;
        out_multi  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr (N=8): a behavioural model pushes the
// expected registered outputs per drive; they are popped after the clock edge.
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_en;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_multi;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       multi;
  } exp_t;

  exp_t sb[$];

  logic       m_valid;
  logic [2:0] m_idx;
  logic [7:0] m_onehot;
  logic       m_multi;
  int         m_ptr;

  prio_encoder_rr #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rr_en      (rr_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_multi  (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_idx    = 3'd0;
    m_onehot = 8'h00;
    m_multi  = 1'b0;
    m_ptr    = 7;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_idx"}, 32'(out_idx), 0);
    chk({tag, "_onehot"}, 32'(out_onehot), 0);
    chk({tag, "_multi"}, 32'(out_multi), 0);
    model_reset();
    @(negedge clk);
    req       = 8'h00;
    rr_en     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
  endtask

  task automatic drive(input logic [7:0] r, input logic rr, input logic rdy);
    exp_t e;
    int   g;
    int   p;
    int   cnt;
    @(negedge clk);
    req       = r;
    rr_en     = rr;
    out_ready = rdy;
    if (!m_valid || rdy) begin
      if (r != 8'h00) begin
        g = -1;
        if (!rr) begin
          for (int i = 7; i >= 0; i--) if (g < 0 && r[i]) g = i;
        end else begin
          p = m_ptr;
          for (int k = 0; k < 8; k++) begin
            if (g < 0 && r[p]) g = p;
            p = (p == 0) ? 7 : p - 1;
          end
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(r[i]);
        m_valid  = 1'b1;
        m_idx    = 3'(g);
        m_onehot = 8'h01 << g;
        m_multi  = (cnt > 1);
        if (rr) m_ptr = (g == 0) ? 7 : g - 1;
      end else begin
        m_valid  = 1'b0;
        m_onehot = 8'h00;
        m_multi  = 1'b0;
      end
    end
    e.v     = m_valid;
    e.idx   = m_idx;
    e.oh    = m_onehot;
    e.multi = m_multi;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_valid", 32'(out_valid), 32'(e.v));
    chk("sb_idx", 32'(out_idx), 32'(e.idx));
    chk("sb_onehot", 32'(out_onehot), 32'(e.oh));
    chk("sb_multi", 32'(out_multi), 32'(e.multi));
  endtask

  int seq_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 8'h00;
    rr_en     = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_onehot", 32'(out_onehot), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Some traffic, then reset mid-stream with a stalled grant held.
    drive(8'h30, 1'b1, 1'b1);
    drive(8'h30, 1'b1, 1'b0);
    do_reset("t1_rst");
    drive(8'hFF, 1'b1, 1'b1);
    chk("t1_idx", 32'(out_idx), 7);
    chk("t1_valid", 32'(out_valid), 1);

    // Fixed priority.
    drive(8'b0010_0100, 1'b0, 1'b1);
    chk("t2_idx", 32'(out_idx), 5);
    chk("t2_onehot", 32'(out_onehot), 32'h20);
    chk("t2_multi", 32'(out_multi), 1);
    drive(8'h01, 1'b0, 1'b1);
    chk("t2b_idx", 32'(out_idx), 0);
    chk("t2b_multi", 32'(out_multi), 0);

    // Round-robin rotation from a fresh pointer.
    do_reset("t3_rst");
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 1'b1, 1'b1);
      chk("t3_seq", 32'(out_idx), 32'(seq_exp[k]));
    end

    // Wrap and skip.
    drive(8'hFF, 1'b1, 1'b1);
    chk("t4_g6", 32'(out_idx), 6);
    drive(8'b0100_0001, 1'b1, 1'b1);
    chk("t4_wrap", 32'(out_idx), 0);
    drive(8'b0100_0001, 1'b1, 1'b1);
    chk("t4_skip", 32'(out_idx), 6);

    // Stall holds the grant; pointer survives fixed-mode use.
    drive(8'h08, 1'b0, 1'b1);
    chk("t5_idx3", 32'(out_idx), 3);
    for (int k = 0; k < 3; k++) begin
      drive(8'h80, 1'b0, 1'b0);
      chk("t5_hold_idx", 32'(out_idx), 3);
      chk("t5_hold_oh", 32'(out_onehot), 32'h08);
    end
    drive(8'h80, 1'b0, 1'b1);
    chk("t5_idx7", 32'(out_idx), 7);
    drive(8'hFF, 1'b1, 1'b1);
    chk("t5_ptr_kept", 32'(out_idx), 5);

    // Empty request and load while invalid without ready.
    drive(8'h00, 1'b0, 1'b1);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_onehot", 32'(out_onehot), 0);
    chk("t6_idx_held", 32'(out_idx), 5);
    drive(8'h02, 1'b0, 1'b0);
    chk("t6_load", 32'(out_idx), 1);
    chk("t6_valid2", 32'(out_valid), 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 300; k++) begin
      drive(8'($urandom_range(0, 255)) & ((k % 5 == 0) ? 8'h00 : 8'hFF),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
